// File: rtl/dice_i2c_slave.sv
// I2C target bridging the open-drain SDA/SCL pins to the dice core register file.
// Decodes START/STOP, matches the device address, tracks a sub-address and strobes the core.
module dice_i2c_slave #(
  parameter logic [6:0] I2C_ADDR    = 7'h70,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  // Core handshake: reg_we/reg_re are single-cycle strobes with no backpressure;
  // the core presents reg_rdata for reg_addr in the cycle after reg_re, where it is sampled.
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WRITE, WR_ACK, READ, MACK, WAIT_STOP
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_prev, sda_prev;
  logic rise_q, fall_q, start_q, stop_q, bit_q;

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_d, wdata_d;
  logic       rw_q, rw_d, we_d, re_d, oe_d, busy_d, load_q;

  assign sda_out = 1'b0;
  assign scl_s   = scl_sync[SYNC_STAGES-1];
  assign sda_s   = sda_sync[SYNC_STAGES-1];

  // Synchronizers idle high so reset never looks like a bus edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
      rise_q   <= scl_s & ~scl_prev;
      fall_q   <= ~scl_s & scl_prev;
      start_q  <= scl_s & sda_prev & ~sda_s;
      stop_q   <= scl_s & ~sda_prev & sda_s;
      bit_q    <= sda_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    addr_d  = reg_addr;
    wdata_d = reg_wdata;
    we_d    = 1'b0;
    re_d    = 1'b0;
    oe_d    = sda_oe;
    busy_d  = busy;
    if (load_q) shift_d = reg_rdata;
    if (start_q) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_q) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR, SUB, WRITE: begin
          if (rise_q) begin
            shift_d = {shift_q[6:0], bit_q};
            cnt_d   = cnt_q + 4'd1;
            if (state_q == WRITE && cnt_q == 4'd7) begin
              we_d    = 1'b1;
              wdata_d = {shift_q[6:0], bit_q};
            end
          end else if (fall_q && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == I2C_ADDR) begin
                state_d = ADDR_ACK;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
                rw_d    = shift_q[0];
              end else begin
                state_d = IDLE;
              end
            end else if (state_q == SUB) begin
              addr_d  = shift_q;
              state_d = SUB_ACK;
              oe_d    = 1'b1;
            end else begin
              state_d = WR_ACK;
              oe_d    = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          // The read fetch is issued while the master samples ACK, so data is loaded before the fall.
          if (rise_q && rw_q) begin
            re_d = 1'b1;
          end else if (fall_q) begin
            if (rw_q) begin
              state_d = READ;
              oe_d    = ~shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
              cnt_d   = 4'd1;
            end else begin
              state_d = SUB;
              oe_d    = 1'b0;
            end
          end
        end
        SUB_ACK: begin
          if (fall_q) begin
            state_d = WRITE;
            oe_d    = 1'b0;
          end
        end
        WR_ACK: begin
          if (fall_q) begin
            state_d = WRITE;
            oe_d    = 1'b0;
            addr_d  = reg_addr + 8'd1;
          end
        end
        READ: begin
          if (fall_q) begin
            if (cnt_q == 4'd8) begin
              state_d = MACK;
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
            end else begin
              oe_d    = ~shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        MACK: begin
          if (rise_q) begin
            if (bit_q) begin
              state_d = WAIT_STOP;
            end else begin
              addr_d = reg_addr + 8'd1;
              re_d   = 1'b1;
            end
          end else if (fall_q) begin
            state_d = READ;
            oe_d    = ~shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      shift_q   <= 8'd0;
      rw_q      <= 1'b0;
      reg_addr  <= 8'd0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      load_q    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      reg_addr  <= addr_d;
      reg_wdata <= wdata_d;
      reg_we    <= we_d;
      reg_re    <= re_d;
      load_q    <= reg_re;
      sda_oe    <= oe_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_dice_i2c_slave.sv
// Bench for dice_i2c_slave: bit-level I2C master, register-file core model and strobe scoreboard.
module tb_dice_i2c_slave;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_out, sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_we_q[$];
  logic [7:0]  exp_re_q[$];
  logic [7:0]  ref_mem[256];
  logic [7:0]  core_mem[256];
  logic        core_ready = 1'b0;
  logic [7:0]  m_ptr;
  logic        oe_prev = 1'b0;
  logic        oe_seen = 1'b0;

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  dice_i2c_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_out   (sda_out),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'(a * 3 + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Core register file: write on reg_we, registered read data the cycle after reg_re.
  always @(posedge clk) begin
    if (!core_ready) begin
      for (int i = 0; i < 256; i++) core_mem[i] <= init_val(i);
      core_ready <= 1'b1;
    end else begin
      if (reg_we) core_mem[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= core_mem[reg_addr];
    end
  end

  // Strobe scoreboard and SDA timing rule.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) begin
        check("we_re_exclusive", 32'(reg_re), 32'd0);
        check("we_expected", 32'(exp_we_q.size() > 0), 32'd1);
        if (exp_we_q.size() > 0) check("we_addr_data", 32'({reg_addr, reg_wdata}), 32'(exp_we_q.pop_front()));
      end
      if (reg_re) begin
        check("re_expected", 32'(exp_re_q.size() > 0), 32'd1);
        if (exp_re_q.size() > 0) check("re_addr", 32'(reg_addr), 32'(exp_re_q.pop_front()));
      end
      if (sda_oe && !oe_prev) check("oe_rise_scl_low", 32'(scl_in), 32'd0);
      if (sda_oe) oe_seen = 1'b1;
    end
    oe_prev = sda_oe;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic b, output logic s);
    sda_drv = b;
    wait_clk(Q);
    scl_drv = 1'b1;
    wait_clk(Q);
    s = sda_in;
    wait_clk(Q);
    scl_drv = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    wait_clk(Q);
    scl_drv = 1'b1;
    wait_clk(Q);
    sda_drv = 1'b0;
    wait_clk(Q);
    scl_drv = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_clk(Q);
    scl_drv = 1'b1;
    wait_clk(Q);
    sda_drv = 1'b1;
    wait_clk(Q + 2);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(d[i], s);
    put_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, s);
      d[i] = s;
    end
    put_bit(mack, s);
  endtask

  task automatic send_chk(input string name, input logic [7:0] d, input logic exp_ack);
    logic a;
    write_byte(d, a);
    check(name, 32'(a), 32'(exp_ack));
  endtask

  task automatic set_sub(input string name, input logic [7:0] sub);
    send_chk(name, sub, 1'b0);
    m_ptr = sub;
  endtask

  task automatic data_wr(input string name, input logic [7:0] d);
    exp_we_q.push_back({m_ptr, d});
    ref_mem[m_ptr] = d;
    m_ptr = m_ptr + 8'd1;
    send_chk(name, d, 1'b0);
  endtask

  // Reads one byte at the model pointer; an ACK advances the pointer and triggers the next fetch.
  task automatic rd_chk(input string name, input logic mack, output logic [7:0] d);
    logic [7:0] exp_d;
    exp_d = ref_mem[m_ptr];
    if (!mack) begin
      m_ptr = m_ptr + 8'd1;
      exp_re_q.push_back(m_ptr);
    end
    read_byte(mack, d);
    check(name, 32'(d), 32'(exp_d));
  endtask

  initial begin
    logic [7:0] d;
    logic s;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    m_ptr = 8'h00;

    wait_clk(3);
    check("rst_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outputs", 32'({reg_addr, reg_wdata, reg_we, reg_re, sda_out}), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);
    check("post_rst_addr", 32'(reg_addr), 32'd0);

    // T1: two sequential writes from sub-address 0x0A
    i2c_start();
    send_chk("t1_addr", 8'hE0, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    set_sub("t1_sub", 8'h0A);
    data_wr("t1_d0", 8'h55);
    data_wr("t1_d1", 8'h1F);
    i2c_stop();
    check("t1_busy_stop", 32'(busy), 32'd0);
    check("t1_addr_pin", 32'(reg_addr), 32'h0C);

    // T2: writes across 0x7F/0x80 and wrap 0xFF -> 0x00
    i2c_start();
    send_chk("t2_addr", 8'hE0, 1'b0);
    set_sub("t2_sub", 8'h7F);
    data_wr("t2_d0", 8'hFA);
    data_wr("t2_d1", 8'h4D);
    i2c_stop();
    i2c_start();
    send_chk("t2_addr_b", 8'hE0, 1'b0);
    set_sub("t2_sub_b", 8'hFF);
    data_wr("t2_d2", 8'h01);
    data_wr("t2_d3", 8'h02);
    i2c_stop();
    check("t2_wrap_pin", 32'(reg_addr), 32'h01);

    // T3: set sub 0x7E, repeated START, read two bytes (ACK then NACK)
    i2c_start();
    send_chk("t3_addr", 8'hE0, 1'b0);
    set_sub("t3_sub", 8'h7E);
    i2c_start();
    exp_re_q.push_back(m_ptr);
    send_chk("t3_addr_rd", 8'hE1, 1'b0);
    rd_chk("t3_rd0", 1'b0, d);
    check("t3_rd0_pin", 32'(d), 32'h7B);
    rd_chk("t3_rd1", 1'b1, d);
    check("t3_rd1_pin", 32'(d), 32'hFA);
    oe_seen = 1'b0;
    for (int i = 0; i < 9; i++) put_bit(1'b1, s);
    check("t3_wait_stop_quiet", 32'(oe_seen), 32'd0);
    check("t3_busy_wait", 32'(busy), 32'd1);
    i2c_stop();
    check("t3_addr_pin", 32'(reg_addr), 32'h7F);

    // T4: foreign address is never acknowledged
    oe_seen = 1'b0;
    i2c_start();
    send_chk("t4_addr", 8'hA0, 1'b1);
    send_chk("t4_b1", 8'hE0, 1'b1);
    send_chk("t4_b2", 8'h55, 1'b1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_no_oe", 32'(oe_seen), 32'd0);
    i2c_stop();
    check("t4_addr_keep", 32'(reg_addr), 32'h7F);

    // T6: START coincident with an SCL rise restarts the address byte
    i2c_start();
    put_bit(1'b1, s);
    put_bit(1'b1, s);
    put_bit(1'b1, s);
    sda_drv = 1'b1;
    wait_clk(Q);
    scl_drv = 1'b1;
    sda_drv = 1'b0;
    wait_clk(Q);
    scl_drv = 1'b0;
    wait_clk(Q);
    send_chk("t6_addr", 8'hE0, 1'b0);
    set_sub("t6_sub", 8'h05);
    data_wr("t6_d0", 8'h99);
    i2c_stop();

    // T5a: STOP after 5 data bits discards the partial byte
    i2c_start();
    send_chk("t5_addr", 8'hE0, 1'b0);
    set_sub("t5_sub", 8'h20);
    for (int i = 0; i < 5; i++) put_bit(i[0], s);
    i2c_stop();
    check("t5_busy_stop", 32'(busy), 32'd0);
    check("t5_addr_pin", 32'(reg_addr), 32'h20);

    // T5b: reset in the middle of a read byte (0x61: fifth bit driven low)
    i2c_start();
    exp_re_q.push_back(m_ptr);
    send_chk("t5_addr_rd", 8'hE1, 1'b0);
    for (int i = 0; i < 4; i++) put_bit(1'b1, s);
    wait_clk(2);
    check("t5_oe_driving", 32'(sda_oe), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_oe", 32'(sda_oe), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_outputs", 32'({reg_addr, reg_wdata, reg_we, reg_re}), 32'd0);
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    m_ptr = 8'h00;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);

    // T5c: read without SUB uses the reset sub-address
    i2c_start();
    exp_re_q.push_back(m_ptr);
    send_chk("t5c_addr", 8'hE1, 1'b0);
    rd_chk("t5c_rd", 1'b1, d);
    check("t5c_rd_pin", 32'(d), 32'h02);
    i2c_stop();

    wait_clk(10);
    check("we_queue_drained", 32'(exp_we_q.size()), 32'd0);
    check("re_queue_drained", 32'(exp_re_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
